// File: rtl/inst_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader_pkg
//  Description : Shared types and constants for the instruction loader:
//                FSM state encoding, default halt opcode and the
//                instruction-word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package inst_loader_pkg;

  // Loader FSM states
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,   // idle, waiting for start
    RECEBE  = 2'd1,   // receiving bytes of the current word
    ESCREVE = 2'd2,   // one-cycle memory write of the assembled word
    FIM     = 2'd3    // session finished, pronto/erro held
  } state_t;

  // Value of bits [31:27] that marks a halt instruction
  localparam logic [4:0] HLT_OPCODE_DEF = 5'b00001;

  // Instruction-word width
  localparam int INSTR_W = 32;

endpackage
`default_nettype wire

// File: rtl/inst_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Collects four bytes big-endian into one instruction word.
//                Only the first three bytes are stored; the fourth byte is
//                taken straight from byte_in so the full word is available
//                in the same cycle the last byte is accepted.
//  Ports       : clock, reset      - clock / async active-high reset
//                clear             - discard any partial word
//                accept            - byte_in is taken this cycle
//                byte_in[7:0]      - incoming byte
//                word[31:0]        - stored bytes followed by byte_in
//                word_full         - the 4th byte of a word is accepted now
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
  import inst_loader_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               clear,
  input  logic               accept,
  input  logic [7:0]         byte_in,
  output logic [INSTR_W-1:0] word,
  output logic               word_full
);

  logic [23:0] r_shift;
  logic [1:0]  r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_shift <= 24'd0;
      r_count <= 2'd0;
    end else if (clear) begin
      r_shift <= 24'd0;
      r_count <= 2'd0;
    end else if (accept) begin
      r_shift <= {r_shift[15:0], byte_in};
      // 2-bit counter wraps 3 -> 0 at each word boundary
      r_count <= r_count + 2'd1;
    end
  end

  assign word      = {r_shift, byte_in};
  assign word_full = accept && (r_count == 2'd3);

endmodule
`default_nettype wire

// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_loader
//  Description : Loads num_palavras 32-bit instructions, received as a
//                big-endian byte stream, into instruction memory.
//                Optional macro INST_LOADER_HLT_STOP_EN: a written word whose
//                [31:27] equals HLT_OPCODE ends the session early.
//  Ports       : clock, reset           - clock / async active-high reset
//                start, num_palavras    - begin a session of N words
//                byte_in, byte_valid    - byte stream in
//                byte_ready             - loader accepts a byte
//                mem_we, mem_endereco,
//                mem_dado               - instruction-memory write port
//                ocupado, pronto, erro  - session status
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int         DEPTH      = 32,
  parameter logic [4:0] HLT_OPCODE = HLT_OPCODE_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [5:0]         num_palavras,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               byte_ready,
  output logic               mem_we,
  output logic [INSTR_W-1:0] mem_endereco,
  output logic [INSTR_W-1:0] mem_dado,
  output logic               ocupado,
  output logic               pronto,
  output logic               erro
);

`ifdef INST_LOADER_HLT_STOP_EN
  localparam bit HLT_EN = 1'b1;
`else
  localparam bit HLT_EN = 1'b0;
`endif

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_t             r_state;
  logic [5:0]         r_count;   // latched word count
  logic [5:0]         r_idx;     // current word index

  logic               w_accept;
  logic               w_start_ok;
  logic               w_word_full;
  logic [INSTR_W-1:0] w_word;
  logic [5:0]         w_idx_next;
  logic               w_hlt_stop;

  assign w_accept   = byte_valid && byte_ready;
  assign w_start_ok = start && ((r_state == OCIOSO) || (r_state == FIM));
  assign w_idx_next = r_idx + 6'd1;
  // mem_dado still holds the word being written while in ESCREVE
  assign w_hlt_stop = HLT_EN && (mem_dado[31:27] == HLT_OPCODE);

  byte_packer u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (w_start_ok),
    .accept    (w_accept),
    .byte_in   (byte_in),
    .word      (w_word),
    .word_full (w_word_full)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= OCIOSO;
      r_count      <= 6'd0;
      r_idx        <= 6'd0;
      byte_ready   <= 1'b0;
      mem_we       <= 1'b0;
      mem_endereco <= '0;
      mem_dado     <= '0;
      ocupado      <= 1'b0;
      pronto       <= 1'b0;
      erro         <= 1'b0;
    end else begin
      case (r_state)
        OCIOSO, FIM: begin
          if (start) begin
            r_count <= num_palavras;
            r_idx   <= 6'd0;
            pronto  <= 1'b0;
            erro    <= 1'b0;
            if (num_palavras == 6'd0) begin
              r_state <= FIM;
              pronto  <= 1'b1;
            end else if ({26'd0, num_palavras} > DEPTH_W) begin
              r_state <= FIM;
              pronto  <= 1'b1;
              erro    <= 1'b1;
            end else begin
              r_state    <= RECEBE;
              byte_ready <= 1'b1;
              ocupado    <= 1'b1;
            end
          end
        end
        RECEBE: begin
          if (w_word_full) begin
            r_state      <= ESCREVE;
            byte_ready   <= 1'b0;
            mem_we       <= 1'b1;
            mem_endereco <= {{(INSTR_W-6){1'b0}}, r_idx};
            mem_dado     <= w_word;
          end
        end
        ESCREVE: begin
          mem_we <= 1'b0;
          r_idx  <= w_idx_next;
          if ((w_idx_next == r_count) || w_hlt_stop) begin
            r_state <= FIM;
            ocupado <= 1'b0;
            pronto  <= 1'b1;
          end else begin
            r_state    <= RECEBE;
            byte_ready <= 1'b1;
          end
        end
        default: r_state <= OCIOSO;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inst_loader
//  Description : Self-checking bench for inst_loader. A reference model
//                derives the expected memory writes of each session and
//                pushes them into a queue; an independent monitor pops and
//                compares on every mem_we pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

`ifdef INST_LOADER_HLT_STOP_EN
  localparam bit HLT_EN = 1'b1;
`else
  localparam bit HLT_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  num_palavras;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_endereco;
  logic [31:0] mem_dado;
  logic        ocupado;
  logic        pronto;
  logic        erro;

  always #5 clock = ~clock;

  inst_loader #(.DEPTH(32), .HLT_OPCODE(5'b00001)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .num_palavras (num_palavras),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_endereco (mem_endereco),
    .mem_dado     (mem_dado),
    .ocupado      (ocupado),
    .pronto       (pronto),
    .erro         (erro)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];     // expected writes, oldest first
  logic [31:0] in_words[$];  // words offered for a session
  logic [31:0] send_q[$];    // words the loader will actually consume
  bit          exp_done;
  bit          exp_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the oldest expected write
  always @(negedge clock) begin
    wr_t e;
    if (reset === 1'b0 && mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0h data=%0h required=no_write", mem_endereco, mem_dado);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", mem_endereco, e.addr);
        check("wr_data", mem_dado, e.data);
        check("wr_no_ready", {31'd0, byte_ready}, 32'd0);
      end
    end
  end

  // Reference model: which words get written, and how the session ends
  task automatic model(input int n);
    bit halted = 0;
    wr_t e;
    send_q.delete();
    exp_err  = (n > 32);
    exp_done = 1;
    if (n == 0 || n > 32) return;
    foreach (in_words[i]) begin
      if (i >= n || halted) break;
      send_q.push_back(in_words[i]);
      e.addr = i;
      e.data = in_words[i];
      exp_q.push_back(e);
      if (HLT_EN && in_words[i][31:27] == 5'b00001) halted = 1;
    end
    exp_done = halted || (send_q.size() == n);
  endtask

  // gap: 0 none, 1 toggle every other cycle, 2 random
  task automatic send_byte(input logic [7:0] b, input int gap, input bit poke);
    int guard = 0;
    bit acc = 0;
    while (!acc) begin
      @(negedge clock);
      start   = 1'b0;
      byte_in = b;
      case (gap)
        1:       byte_valid = ~byte_valid;
        2:       byte_valid = ($urandom_range(0, 2) != 0);
        default: byte_valid = 1'b1;
      endcase
      // A start while busy must be ignored
      if (poke && $urandom_range(0, 5) == 0) begin
        start        = 1'b1;
        num_palavras = 6'($urandom);
      end
      acc = byte_valid && byte_ready;
      guard++;
      if (guard > 60) begin
        checks++;
        failures++;
        $display("FAIL byte_accept_timeout actual=no_accept required=accept");
        return;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_mem_we",     {31'd0, mem_we},     32'd0);
    check("rst_ocupado",    {31'd0, ocupado},    32'd0);
    check("rst_pronto",     {31'd0, pronto},     32'd0);
    check("rst_erro",       {31'd0, erro},       32'd0);
    check("rst_addr",       mem_endereco,        32'd0);
    check("rst_data",       mem_dado,            32'd0);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_session(input int n, input int gap, input bit poke);
    int g;
    model(n);
    @(negedge clock);
    start        = 1'b1;
    num_palavras = 6'(n);
    byte_valid   = 1'b0;
    @(negedge clock);
    start = 1'b0;
    if (n == 0 || n > 32) begin
      check("imm_pronto",  {31'd0, pronto},  32'd1);
      check("imm_erro",    {31'd0, erro},    {31'd0, exp_err});
      check("imm_ocupado", {31'd0, ocupado}, 32'd0);
    end else begin
      check("start_ocupado", {31'd0, ocupado},    32'd1);
      check("start_ready",   {31'd0, byte_ready}, 32'd1);
      check("start_pronto",  {31'd0, pronto},     32'd0);
    end
    foreach (send_q[i]) begin
      logic [31:0] w;
      w = send_q[i];
      for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gap, poke);
    end
    @(negedge clock);
    start      = 1'b0;
    byte_valid = 1'b0;
    if (exp_done) begin
      g = 0;
      while (pronto !== 1'b1 && g < 10) begin
        @(negedge clock);
        g++;
      end
      check("end_pronto",  {31'd0, pronto},     32'd1);
      check("end_erro",    {31'd0, erro},       {31'd0, exp_err});
      check("end_ocupado", {31'd0, ocupado},    32'd0);
      check("end_ready",   {31'd0, byte_ready}, 32'd0);
    end else begin
      repeat (4) @(negedge clock);
      check("busy_ocupado", {31'd0, ocupado},    32'd1);
      check("busy_pronto",  {31'd0, pronto},     32'd0);
      check("busy_ready",   {31'd0, byte_ready}, 32'd1);
    end
    check("pending_writes", exp_q.size(), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset        = 1'b1;
    start        = 1'b0;
    num_palavras = 6'd0;
    byte_in      = 8'd0;
    byte_valid   = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    do_reset();

    // Two-word load
    in_words = '{32'h90400005, 32'h7042000A};
    run_session(2, 0, 0);

    // Zero words and too many words
    in_words.delete();
    run_session(0, 0, 0);
    run_session(33, 0, 0);

    // Reset in the middle of a word discards the partial bytes
    @(negedge clock);
    start        = 1'b1;
    num_palavras = 6'd1;
    @(negedge clock);
    start = 1'b0;
    send_byte(8'hAA, 0, 0);
    send_byte(8'hBB, 0, 0);
    do_reset();
    in_words = '{32'h08000000};
    run_session(1, 0, 0);

    // Halt opcode inside a four-word session
    in_words = '{32'h90400005, 32'h08000000};
    run_session(4, 0, 0);
    if (!exp_done) do_reset();

    // Byte_valid toggling on a one-word load
    in_words = '{32'h90400005};
    run_session(1, 1, 0);

    // Full-depth session
    in_words.delete();
    for (int i = 0; i < 32; i++) in_words.push_back($urandom);
    run_session(32, 2, 1);

    // Randomised sessions
    for (int s = 0; s < 25; s++) begin
      case ($urandom_range(0, 9))
        0:       n = 0;
        1:       n = $urandom_range(33, 63);
        default: n = $urandom_range(1, 6);
      endcase
      in_words.delete();
      for (int i = 0; i < n && i < 32; i++) begin
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 4) == 0) w[31:27] = 5'b00001;
        in_words.push_back(w);
      end
      run_session(n, $urandom_range(0, 2), 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
